cpu_state_regs: RTL

//  Architectural state stage of the 16-bit Hack-style CPU, directly downstream of the A-input Mux16.

---
 rtl/hack_cpu_pkg.sv | 22 ++
 rtl/pc_unit.sv | 39 +++
 rtl/cpu_state_regs.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack-style CPU: default widths, C-instruction field
// bit positions and the core run/halt state type.
package hack_cpu_pkg;

  localparam int unsigned DEF_W    = 16;
  localparam int unsigned DEF_PC_W = 15;

  // C-instruction field bit positions
  localparam int unsigned IS_C = 15;
  localparam int unsigned D_A  = 5;
  localparam int unsigned D_D  = 4;
  localparam int unsigned D_M  = 3;
  localparam int unsigned J_LT = 2;
  localparam int unsigned J_EQ = 1;
  localparam int unsigned J_GT = 0;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: hold has priority over load, load over increment.
// The increment wraps modulo 2^PC_W.
module pc_unit
  import hack_cpu_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            load,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] q
);

  logic [PC_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (hold) begin
      q_d = q_q;
    end else if (load) begin
      q_d = din;
    end else begin
      q_d = q_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_state_regs.sv
// Architectural state of the Hack-style CPU: A/D/PC registers, C-instruction decode,
// jump evaluation, data-memory write strobe and jump-to-self halt detection.
module cpu_state_regs
  import hack_cpu_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [W-1:0]    instr,
  input  logic [W-1:0]    mux_y,
  input  logic [W-1:0]    alu_out,
  input  logic            zr,
  input  logic            ng,
  output logic [W-1:0]    a_reg,
  output logic [W-1:0]    d_reg,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] addr_m,
  output logic            write_m,
  output logic            halted
);

  logic [W-1:0]    a_d, a_q;
  logic [W-1:0]    d_d, d_q;
  logic [PC_W-1:0] pc_q;
  state_e          state_q;
  logic            halted_q;

  logic is_c, dest_a, dest_d, dest_m;
  logic load_a, load_d, take, advance, halt_req;

  // Opcode/comp bits are consumed by the ALU and mux, not here.
  logic unused_instr;
  assign unused_instr = ^instr[IS_C-1:D_A+1];

  // Decode
  assign is_c   = instr[IS_C];
  assign dest_a = instr[D_A];
  assign dest_d = instr[D_D];
  assign dest_m = instr[D_M];

  assign load_a = ~is_c | dest_a;
  assign load_d = is_c & dest_d;

  assign take = is_c & ((instr[J_LT] & ng) |
                        (instr[J_EQ] & zr) |
                        (instr[J_GT] & ~ng & ~zr));

  assign advance = en & (state_q == StRun);

  // Only an unconditional jump onto its own address parks the core.
  assign halt_req = advance & take & (instr[J_LT:J_GT] == 3'b111) &
                    (a_q[PC_W-1:0] == pc_q);

  assign write_m = advance & is_c & dest_m & rst_n;

  // A/D next state
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (advance) begin
      if (load_a) a_d = mux_y;
      if (load_d) d_d = alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // Jump target is the A value before this edge's update.
  pc_unit #(
    .PC_W (PC_W)
  ) u_pc_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (~advance),
    .load  (take),
    .din   (a_q[PC_W-1:0]),
    .q     (pc_q)
  );

  // Run/halt FSM; HALT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (halt_req) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        StHalt: begin
          state_q  <= StHalt;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= StRun;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign a_reg  = a_q;
  assign d_reg  = d_q;
  assign pc     = pc_q;
  assign addr_m = a_q[PC_W-1:0];
  assign halted = halted_q;

endmodule
